instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the pipelined MIPS core. Owns the program counter, drives the word address of the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register for decode. Handles pipeline stall, flush, branch and jump redirects from the ID stage.

## Interface
Parameters:
- `ADDR_W`, 6: instruction-memory word-address width (64 words).
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, 32'h0000_0000: instruction loaded into IF/ID on reset or flush.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hold the PC and IF/ID contents this cycle.
- `flush` in 1: replace the IF/ID contents with a bubble.
- `pc_src` in 1: branch taken; the next PC is `branch_target`.
- `branch_target` in 32: byte address of the taken branch.
- `jump` in 1: the next PC is `jump_target`.
- `jump_target` in 32: byte address of the jump.
- `imem_addr` out ADDR_W: word address to instruction memory, equal to `pc[ADDR_W+1:2]`.
- `imem_data` in 32: instruction word returned combinationally by instruction memory.
- `pc` out 32: current PC register.
- `if_id_instr` out 32: registered instruction for decode.
- `if_id_pc_plus4` out 32: registered PC+4 of that instruction.
- `if_id_valid` out 1: 1 when `if_id_instr` is a real fetched instruction. 0 when it is a bubble.

## Operation
- `pc_plus4 = pc + 4`, computed in 32 bits and wrapping modulo 2^32.
- `imem_addr` uses only the bits `pc[ADDR_W+1:2]`. PCs beyond the memory size wrap onto memory words, with no error.
- PC next-state priority, evaluated each edge:
  1. `reset` sets `RESET_PC`.
  2. `stall` holds the current value.
  3. `jump` loads `jump_target`.
  4. `pc_src` loads `branch_target`.
  5. Otherwise the PC loads `pc_plus4`.
- On every PC load, bits [1:0] are forced to 2'b00, so misaligned targets are silently aligned.
- IF/ID next-state priority:
  1. `reset` loads `NOP_INSTR`, PC+4 = 0, valid = 0.
  2. `stall` holds all three fields.
  3. `flush` loads `NOP_INSTR`, PC+4 = 0, valid = 0.
  4. Otherwise the register loads `imem_data`, `pc_plus4`, and valid = 1.
- `stall` together with `flush` in the same cycle: stall wins and flush is ignored. The ID instruction that caused the flush is held, so the ID stage reasserts the flush on a later cycle.
- `jump` together with `pc_src`: jump wins.
- A redirect does not itself flush IF/ID. The ID stage must assert `flush` alongside `pc_src` or `jump` to discard the wrong-path fetch.

## Timing
- `imem_addr` is a combinational function of the `pc` register only. It does not depend on any input port in the same cycle.
- Fetch latency: the instruction at PC A appears on `if_id_instr` one edge after `pc` equals A, provided there is no stall or flush.
- Redirect latency: when `pc_src` or `jump` is asserted in cycle N, `pc` equals the target after edge N. The target instruction appears in IF/ID after edge N+1.
- Reset values, all present one edge after `reset` is high:
  - `pc` = `RESET_PC`.
  - `imem_addr` = `RESET_PC[ADDR_W+1:2]`.
  - `if_id_instr` = `NOP_INSTR`.
  - `if_id_pc_plus4` = 0.
  - `if_id_valid` = 0.
- Reset asserted mid-stall or mid-redirect overrides everything at that edge.
- The first valid instruction reaches IF/ID on the first edge after `reset` deasserts.
- There are no combinational paths from inputs to outputs other than the registered behaviour above.

## Configuration
- `FETCH_PERF_EN` defined: adds two outputs, both reset to 0 and wrapping at 2^32.
  - `fetch_count` out 32 increments on each edge where IF/ID loads a valid instruction.
  - `bubble_count` out 32 increments on each edge where `flush` is asserted without `stall`, or `stall` is asserted (excluding reset edges).
- `FETCH_PERF_EN` undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- **Reset and sequential fetch.** Memory word k holds 32'h1000_0000+k; hold `reset` for 2 cycles, then release.
  - After reset: `pc`=0, `if_id_valid`=0.
  - Then `if_id_instr` = 32'h1000_0000, 32'h1000_0001, 32'h1000_0002 on successive edges, with `if_id_pc_plus4` = 4, 8, 12.
- **Stall.** At `pc`=8, assert `stall` for 2 cycles.
  - `pc` stays 8 and IF/ID stays on the word-1 instruction for 2 edges.
  - After `stall` drops, the word-2 instruction loads.
- **Branch with flush.** Assert `pc_src`=1, `branch_target`=32'h0000_0042, and `flush`=1 for one cycle.
  - Next edge: `pc`=32'h40 (aligned), `if_id_valid`=0, `if_id_instr`=`NOP_INSTR`.
  - Following edge: `if_id_instr`=32'h1000_0010.
- **Jump beats branch, stall beats flush.**
  - `jump`=1 with `jump_target`=32'h20 and `pc_src`=1 with `branch_target`=32'h80: `pc`=32'h20.
  - `stall`=1 with `flush`=1: IF/ID is unchanged and valid stays 1.
- **Wrap-around.**
  - `jump_target`=32'hFC: `imem_addr`=63; next PC = 32'h100 gives `imem_addr`=0.
  - `pc`=32'hFFFF_FFFC: `pc_plus4`=0.
- **Performance counters, with `FETCH_PERF_EN` defined.** Run 10 fetches, then 3 stall cycles, then 1 flush.
  - `fetch_count`=10, `bubble_count`=4.
  - Reset returns both counters to 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the pipelined MIPS core.
// Owns the PC, addresses the combinational instruction memory and captures
// the returned word into the IF/ID register. Stall beats flush, jump beats
// branch, reset beats everything.
// Optional feature macro: FETCH_PERF_EN adds fetch_count / bubble_count.
module instruction_fetch #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              pc_src,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_plus4,
`ifdef FETCH_PERF_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count,
`endif
  output logic              if_id_valid
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_instr_reg;
  logic [31:0] if_id_pc_plus4_reg;
  logic        if_id_valid_reg;

  assign pc_plus4       = pc_reg + 32'd4;
  assign imem_addr      = pc_reg[ADDR_W+1:2];
  assign pc             = pc_reg;
  assign if_id_instr    = if_id_instr_reg;
  assign if_id_pc_plus4 = if_id_pc_plus4_reg;
  assign if_id_valid    = if_id_valid_reg;

  // Next-PC select for the non-reset, non-stall case; targets are word-aligned.
  always_comb begin
    pc_next = pc_plus4;
    if (jump) begin
      pc_next = {jump_target[31:2], 2'b00};
    end else if (pc_src) begin
      pc_next = {branch_target[31:2], 2'b00};
    end
  end

  // PC register: reset, then hold on stall, else advance or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (!stall) begin
      pc_reg <= pc_next;
    end
  end

  // IF/ID register: stall holds, flush inserts a bubble, else capture the fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instr_reg    <= NOP_INSTR;
      if_id_pc_plus4_reg <= 32'd0;
      if_id_valid_reg    <= 1'b0;
    end else if (stall) begin
      if_id_instr_reg    <= if_id_instr_reg;
      if_id_pc_plus4_reg <= if_id_pc_plus4_reg;
      if_id_valid_reg    <= if_id_valid_reg;
    end else if (flush) begin
      if_id_instr_reg    <= NOP_INSTR;
      if_id_pc_plus4_reg <= 32'd0;
      if_id_valid_reg    <= 1'b0;
    end else begin
      if_id_instr_reg    <= imem_data;
      if_id_pc_plus4_reg <= pc_plus4;
      if_id_valid_reg    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] bubble_count_reg;

  assign fetch_count  = fetch_count_reg;
  assign bubble_count = bubble_count_reg;

  // Performance counters: valid loads into IF/ID, and stall/flush bubble cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_reg  <= 32'd0;
      bubble_count_reg <= 32'd0;
    end else begin
      if (!stall && !flush) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (stall || flush) begin
        bubble_count_reg <= bubble_count_reg + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes the hand-computed
// post-edge state into a queue; a monitor pops and compares after each edge.
module tb_instruction_fetch;

  typedef struct {
    string       name;
    logic        chk_pipe;
    logic [31:0] pc;
    logic [5:0]  addr;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        chk_perf;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  logic [31:0] mem [64];
  exp_t        scb_q[$];
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  instruction_fetch #(
    .ADDR_W(6), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_src(pc_src), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
    .if_id_valid(if_id_valid)
  );

  function automatic exp_t ep(string n, logic [31:0] p, logic [5:0] a,
                              logic [31:0] i, logic [31:0] p4, logic v);
    exp_t e;
    e.name = n; e.chk_pipe = 1'b1; e.pc = p; e.addr = a; e.instr = i;
    e.pp4 = p4; e.valid = v; e.chk_perf = 1'b0; e.fc = 32'd0; e.bc = 32'd0;
    return e;
  endfunction

  function automatic exp_t ec(string n, logic [31:0] f, logic [31:0] b);
    exp_t e;
    e = ep(n, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0);
    e.chk_pipe = 1'b0; e.chk_perf = 1'b1; e.fc = f; e.bc = b;
    return e;
  endfunction

  function automatic exp_t nochk(string n);
    exp_t e;
    e = ep(n, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0);
    e.chk_pipe = 1'b0;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the expected state after the edge.
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic ps, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input exp_t e);
    reset = r; stall = st; flush = fl; pc_src = ps; branch_target = bt;
    jump = jp; jump_target = jt;
    scb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one comparison per transaction, sampled 1ns after the edge.
  always @(posedge clk) begin
    #1;
    if (scb_q.size() > 0) begin
      exp_t e;
      logic ok;
      e = scb_q.pop_front();
      ok = 1'b1;
      if (e.chk_pipe) begin
        ok = (pc === e.pc) && (imem_addr === e.addr) && (if_id_instr === e.instr)
             && (if_id_pc_plus4 === e.pp4) && (if_id_valid === e.valid);
        checks++;
        if (ok) begin
          passed++;
          $display("txn %s: pc=%h addr=%0d instr=%h pp4=%h v=%b ok", e.name, pc,
                   imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid);
        end else begin
          $display("FAIL %s: got pc=%h addr=%0d instr=%h pp4=%h v=%b, want pc=%h addr=%0d instr=%h pp4=%h v=%b",
                   e.name, pc, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
                   e.pc, e.addr, e.instr, e.pp4, e.valid);
        end
      end
`ifdef FETCH_PERF_EN
      if (e.chk_perf) begin
        checks++;
        if (fetch_count === e.fc && bubble_count === e.bc) begin
          passed++;
          $display("txn %s: fetch_count=%0d bubble_count=%0d ok", e.name, fetch_count, bubble_count);
        end else begin
          $display("FAIL %s: got fetch_count=%0d bubble_count=%0d, want %0d %0d",
                   e.name, fetch_count, bubble_count, e.fc, e.bc);
        end
      end
`endif
    end
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    @(negedge clk);
    // reset and sequential fetch
    step(1,0,0,0,0,0,0, ep("reset1",   32'h0,  6'd0,  32'h0,         32'h0,  1'b0));
    step(1,0,0,0,0,0,0, ep("reset2",   32'h0,  6'd0,  32'h0,         32'h0,  1'b0));
    step(0,0,0,0,0,0,0, ep("fetch0",   32'h4,  6'd1,  32'h1000_0000, 32'h4,  1'b1));
    step(0,0,0,0,0,0,0, ep("fetch1",   32'h8,  6'd2,  32'h1000_0001, 32'h8,  1'b1));
    // stall two cycles at pc=8
    step(0,1,0,0,0,0,0, ep("stall_a",  32'h8,  6'd2,  32'h1000_0001, 32'h8,  1'b1));
    step(0,1,0,0,0,0,0, ep("stall_b",  32'h8,  6'd2,  32'h1000_0001, 32'h8,  1'b1));
    step(0,0,0,0,0,0,0, ep("fetch2",   32'hC,  6'd3,  32'h1000_0002, 32'hC,  1'b1));
    // branch to misaligned 0x42 with flush
    step(0,0,1,1,32'h42,0,0, ep("br_flush", 32'h40, 6'd16, 32'h0,   32'h0,  1'b0));
    step(0,0,0,0,0,0,0, ep("br_tgt",   32'h44, 6'd17, 32'h1000_0010, 32'h44, 1'b1));
    // jump beats branch (no flush: wrong-path word still captured)
    step(0,0,0,1,32'h80,1,32'h20, ep("jmp_win", 32'h20, 6'd8, 32'h1000_0011, 32'h48, 1'b1));
    // stall beats flush
    step(0,1,1,0,0,0,0, ep("stl_fl",   32'h20, 6'd8,  32'h1000_0011, 32'h48, 1'b1));
    step(0,0,0,0,0,0,0, ep("jmp_tgt",  32'h24, 6'd9,  32'h1000_0008, 32'h24, 1'b1));
    // wrap of memory index
    step(0,0,0,0,0,1,32'hFC, ep("jmp_fc", 32'hFC, 6'd63, 32'h1000_0009, 32'h28, 1'b1));
    step(0,0,0,0,0,0,0, ep("wrap_mem", 32'h100, 6'd0, 32'h1000_003F, 32'h100, 1'b1));
    // PC wrap at 2^32, misaligned jump target
    step(0,0,0,0,0,1,32'hFFFF_FFFE, ep("jmp_top", 32'hFFFF_FFFC, 6'd63, 32'h1000_0000, 32'h104, 1'b1));
    step(0,0,0,0,0,0,0, ep("wrap_pc",  32'h0,  6'd0,  32'h1000_003F, 32'h0,  1'b1));
    // plain flush, then stall holds the bubble
    step(0,0,1,0,0,0,0, ep("flush",    32'h4,  6'd1,  32'h0,         32'h0,  1'b0));
    step(0,1,0,0,0,0,0, ep("stl_bub",  32'h4,  6'd1,  32'h0,         32'h0,  1'b0));
    step(0,0,0,0,0,0,0, ep("resume",   32'h8,  6'd2,  32'h1000_0001, 32'h8,  1'b1));
    // reset overrides stall and jump
    step(1,1,0,0,0,1,32'h80, ep("rst_ovr", 32'h0, 6'd0, 32'h0, 32'h0, 1'b0));
    step(0,0,0,0,0,0,0, ep("post_rst", 32'h4,  6'd1,  32'h1000_0000, 32'h4,  1'b1));
`ifdef FETCH_PERF_EN
    step(1,0,0,0,0,0,0, ec("perf_rst", 32'd0, 32'd0));
    for (int i = 0; i < 9; i++) step(0,0,0,0,0,0,0, nochk("perf_fetch"));
    step(0,0,0,0,0,0,0, ec("perf_10f", 32'd10, 32'd0));
    step(0,1,0,0,0,0,0, nochk("perf_stall"));
    step(0,1,0,0,0,0,0, nochk("perf_stall"));
    step(0,1,0,0,0,0,0, ec("perf_3s", 32'd10, 32'd3));
    step(0,0,1,0,0,0,0, ec("perf_fl", 32'd10, 32'd4));
    step(1,1,0,0,0,0,0, ec("perf_rst2", 32'd0, 32'd0));
`endif
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; jump = 1'b0;
    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && scb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (scb_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", scb_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
